// File: rtl/image_fetch.sv
// Strided read sequencer for image_mem: one read per cycle, returns buffered and streamed out with a last flag.
// First word is valid 2+MEM_LATENCY cycles after the command handshake; reads pause when credit reaches FIFO_DEPTH.

module image_fetch_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_wr_vld,
    input  logic [W-1:0] i_wr_dat,
    input  logic         i_rd_rdy,
    output logic         o_rd_vld,
    output logic [W-1:0] o_rd_dat
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_cnt;
    logic          w_rd;

    assign o_rd_vld = (r_cnt != '0);
    assign o_rd_dat = r_mem[r_rd_ptr];
    assign w_rd     = o_rd_vld & i_rd_rdy;

    // Occupancy is bounded by the caller's credit, so no full check is needed here.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (i_wr_vld) begin
                r_mem[r_wr_ptr] <= i_wr_dat;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({i_wr_vld, w_rd})
                2'b10:   r_cnt <= r_cnt + CNT_ONE;
                2'b01:   r_cnt <= r_cnt - CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

module image_fetch #(
    parameter int GROUP_NB    = 1,
    parameter int IMG_WIDTH   = 16,
    parameter int MEM_AWIDTH  = 16,
    parameter int CNT_WIDTH   = 16,
    parameter int MEM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_val,
    output logic                          cfg_rdy,
    input  logic [MEM_AWIDTH-1:0]         cfg_addr,
    input  logic [MEM_AWIDTH-1:0]         cfg_stride,
    input  logic [CNT_WIDTH-1:0]          cfg_count,
    output logic                          mem_rd_val,
    output logic [MEM_AWIDTH-1:0]         mem_rd_addr,
    input  logic [GROUP_NB*IMG_WIDTH-1:0] mem_rd_data,
    input  logic                          mem_rd_data_val,
    output logic                          str_val,
    input  logic                          str_rdy,
    output logic [GROUP_NB*IMG_WIDTH-1:0] str_data,
    output logic                          str_last,
    output logic                          busy
);
    localparam int DW  = GROUP_NB * IMG_WIDTH;
    localparam int CRW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CRW-1:0]       CREDIT_MAX = CRW'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t                 r_state;
    logic [MEM_AWIDTH-1:0]  r_addr;
    logic [MEM_AWIDTH-1:0]  r_stride;
    logic [CNT_WIDTH-1:0]   r_count;
    logic [CNT_WIDTH-1:0]   r_issue_left;
    logic [CNT_WIDTH-1:0]   r_out_cnt;
    logic [CRW-1:0]         r_credit;
    logic                   r_mem_rd_val;
    logic [MEM_AWIDTH-1:0]  r_mem_rd_addr;
    logic [MEM_LATENCY-1:0] r_pend;

    logic          w_cfg_hs;
    logic          w_out_hs;
    logic          w_credit_ok;
    logic          w_issue_first;
    logic          w_issue_more;
    logic          w_issue;
    logic          w_last_hs;
    logic          w_fifo_wr;
    logic          w_fifo_vld;
    logic [DW-1:0] w_fifo_dat;

    assign cfg_rdy     = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign mem_rd_val  = r_mem_rd_val;
    assign mem_rd_addr = r_mem_rd_addr;
    assign str_val     = w_fifo_vld;
    assign str_data    = w_fifo_dat;
    assign str_last    = w_fifo_vld && (r_out_cnt == r_count - CNT_ONE);

    assign w_cfg_hs      = cfg_val && (r_state == S_IDLE);
    assign w_out_hs      = w_fifo_vld && str_rdy;
    // A word leaving this cycle frees its credit in time for the next read.
    assign w_credit_ok   = (r_credit < CREDIT_MAX) || w_out_hs;
    assign w_issue_first = w_cfg_hs && (cfg_count != '0);
    assign w_issue_more  = (r_state == S_ISSUE) && (r_issue_left != '0) && w_credit_ok;
    assign w_issue       = w_issue_first || w_issue_more;
    assign w_last_hs     = w_out_hs && (r_out_cnt == r_count - CNT_ONE);
    // Only returns lined up with a read we issued are kept; stale ones after a reset fall out here.
    assign w_fifo_wr     = mem_rd_data_val && r_pend[MEM_LATENCY-1] && (r_state != S_IDLE);

    image_fetch_fifo #(
        .W     (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .i_wr_vld (w_fifo_wr),
        .i_wr_dat (mem_rd_data),
        .i_rd_rdy (str_rdy),
        .o_rd_vld (w_fifo_vld),
        .o_rd_dat (w_fifo_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_stride      <= '0;
            r_count       <= '0;
            r_issue_left  <= '0;
            r_out_cnt     <= '0;
            r_credit      <= '0;
            r_mem_rd_val  <= 1'b0;
            r_mem_rd_addr <= '0;
            r_pend        <= '0;
        end else begin
            r_mem_rd_val <= w_issue;
            r_pend[0]    <= r_mem_rd_val;
            for (int k = 1; k < MEM_LATENCY; k++) begin
                r_pend[k] <= r_pend[k-1];
            end

            if (w_issue_first) begin
                r_mem_rd_addr <= cfg_addr;
            end else if (w_issue_more) begin
                r_mem_rd_addr <= r_addr;
            end

            r_credit <= r_credit + {{(CRW-1){1'b0}}, w_issue} - {{(CRW-1){1'b0}}, w_out_hs};

            if (w_cfg_hs) begin
                r_out_cnt <= '0;
            end else if (w_out_hs) begin
                r_out_cnt <= r_out_cnt + CNT_ONE;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_cfg_hs) begin
                        r_stride     <= cfg_stride;
                        r_count      <= cfg_count;
                        r_addr       <= cfg_addr + cfg_stride;
                        r_issue_left <= cfg_count - CNT_ONE;
                        if (cfg_count != '0) begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (r_issue_left == '0) begin
                        r_state <= S_DRAIN;
                    end else if (w_issue_more) begin
                        r_addr       <= r_addr + r_stride;
                        r_issue_left <= r_issue_left - CNT_ONE;
                    end
                end
                S_DRAIN: begin
                    if (w_last_hs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_image_fetch.sv
// Bench for image_fetch: latency-accurate memory model, stream collector and list-based reference expectations.
module tb_image_fetch;
    localparam int GN = 1, IW = 16, AW = 16, CW = 16, LAT = 2, DEPTH = 4;
    localparam int DW = GN * IW;

    logic          clk, rst, cfg_val, cfg_rdy;
    logic [AW-1:0] cfg_addr, cfg_stride;
    logic [CW-1:0] cfg_count;
    logic          mem_rd_val;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          mem_rd_data_val;
    logic          str_val, str_rdy, str_last, busy;
    logic [DW-1:0] str_data;

    image_fetch #(
        .GROUP_NB(GN), .IMG_WIDTH(IW), .MEM_AWIDTH(AW), .CNT_WIDTH(CW),
        .MEM_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .cfg_val(cfg_val), .cfg_rdy(cfg_rdy),
        .cfg_addr(cfg_addr), .cfg_stride(cfg_stride), .cfg_count(cfg_count),
        .mem_rd_val(mem_rd_val), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .mem_rd_data_val(mem_rd_data_val),
        .str_val(str_val), .str_rdy(str_rdy), .str_data(str_data),
        .str_last(str_last), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory answers exactly LAT cycles after each read strobe.
    logic [DW-1:0] mem [0:65535];
    bit            pv [LAT];
    logic [DW-1:0] pd [LAT];
    always @(posedge clk) begin
        pv[0] <= mem_rd_val;
        pd[0] <= mem[mem_rd_addr];
        for (int k = 1; k < LAT; k++) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
        end
    end
    assign mem_rd_data_val = pv[LAT-1];
    assign mem_rd_data     = pd[LAT-1];

    logic [AW-1:0] q_rd [$];
    int            q_rd_cyc [$];
    logic [DW-1:0] q_out [$];
    logic          q_last [$];
    int            q_out_cyc [$];
    int            n_acc, n_rd_tot, n_out_tot, max_out;

    always @(negedge clk) begin
        if (mem_rd_val === 1'b1) begin
            q_rd.push_back(mem_rd_addr);
            q_rd_cyc.push_back(cyc);
            n_rd_tot++;
        end
        if (str_val === 1'b1 && str_rdy === 1'b1) begin
            q_out.push_back(str_data);
            q_last.push_back(str_last);
            q_out_cyc.push_back(cyc);
            n_out_tot++;
        end
        if (cfg_val === 1'b1 && cfg_rdy === 1'b1) n_acc++;
        if (n_rd_tot - n_out_tot > max_out) max_out = n_rd_tot - n_out_tot;
    end

    int n_cmp, n_bad, t0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        q_rd.delete(); q_rd_cyc.delete();
        q_out.delete(); q_last.delete(); q_out_cyc.delete();
        n_acc = 0; n_rd_tot = 0; n_out_tot = 0; max_out = 0;
    endtask

    task automatic wait_out(input int n, input int limit, input string tag);
        int k;
        k = 0;
        while (q_out.size() < n && k < limit) begin
            tick();
            k++;
        end
        check(tag, q_out.size(), n);
    endtask

    // Issues one command and compares the read addresses and output words against the arithmetic model.
    task automatic run_cmd(input logic [AW-1:0] a, input logic [AW-1:0] s, input logic [CW-1:0] n,
                           input int stall, input bit rnd);
        logic [AW-1:0] ea [$];
        logic [AW-1:0] cur;
        int            k;
        bit            done;
        int            exp_stall_rd;
        cur = a;
        for (int i = 0; i < int'(n); i++) begin
            ea.push_back(cur);
            cur = cur + s;
        end
        exp_stall_rd = (int'(n) < DEPTH) ? int'(n) : DEPTH;
        clear_mon();
        tick();
        cfg_addr = a; cfg_stride = s; cfg_count = n; cfg_val = 1'b1;
        str_rdy = (stall == 0);
        t0 = cyc;
        check("cmd_accept_rdy", 32'(cfg_rdy), 1);
        tick();
        cfg_val = 1'b0;
        if (n == '0) begin
            repeat (6) tick();
            check("zero_reads", q_rd.size(), 0);
            check("zero_outputs", q_out.size(), 0);
            check("zero_cfg_rdy", 32'(cfg_rdy), 1);
            check("zero_busy", 32'(busy), 0);
            check("zero_accepted", n_acc, 1);
            return;
        end
        k = 1;
        done = 1'b0;
        while (!done && k < 400 + stall) begin
            if (q_out.size() == int'(n)) begin
                done = 1'b1;
            end else begin
                if (k < stall) begin
                    str_rdy = 1'b0;
                    if (str_val === 1'b1) check("stall_data_stable", 32'(str_data), 32'(mem[ea[0]]));
                end else begin
                    if (k == stall) check("stall_read_count", q_rd.size(), exp_stall_rd);
                    str_rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                tick();
                k++;
            end
        end
        check("cmd_done", 32'(done), 1);
        check("busy_after_last", 32'(busy), 0);
        check("cfg_rdy_after_last", 32'(cfg_rdy), 1);
        check("read_count", q_rd.size(), int'(n));
        for (int i = 0; i < int'(n) && i < q_rd.size(); i++)
            check($sformatf("rd_addr[%0d]", i), 32'(q_rd[i]), 32'(ea[i]));
        check("out_count", q_out.size(), int'(n));
        for (int i = 0; i < int'(n) && i < q_out.size(); i++) begin
            check($sformatf("out_data[%0d]", i), 32'(q_out[i]), 32'(mem[ea[i]]));
            check($sformatf("out_last[%0d]", i), 32'(q_last[i]), 32'(i == int'(n) - 1));
        end
        check("max_outstanding_ok", 32'(max_out <= DEPTH), 1);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; cfg_val = 1'b0; str_rdy = 1'b0;
        cfg_addr = '0; cfg_stride = '0; cfg_count = '0;
        for (int i = 0; i < 65536; i++) mem[i] = DW'(i);
        clear_mon();
        repeat (3) tick();
        check("rst_cfg_rdy", 32'(cfg_rdy), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_rd_val", 32'(mem_rd_val), 0);
        check("rst_mem_rd_addr", 32'(mem_rd_addr), 0);
        check("rst_str_val", 32'(str_val), 0);
        check("rst_str_last", 32'(str_last), 0);
        check("rst_str_data", 32'(str_data), 0);
        rst = 1'b0;
        tick();

        // Linear read with cycle-exact timing.
        run_cmd(16'h0000, 16'h0001, 16'd11, 0, 1'b0);
        for (int i = 0; i < 11 && i < q_rd_cyc.size(); i++)
            check($sformatf("lin_rd_cycle[%0d]", i), q_rd_cyc[i] - t0, 1 + i);
        for (int i = 0; i < 11 && i < q_out_cyc.size(); i++)
            check($sformatf("lin_out_cycle[%0d]", i), q_out_cyc[i] - t0, 2 + LAT + i);

        run_cmd(16'h0000, 16'h0002, 16'd6, 0, 1'b0);
        run_cmd(16'h0001, 16'h0002, 16'd6, 0, 1'b0);
        run_cmd(16'h0000, 16'h0001, 16'd10, 20, 1'b0);
        run_cmd(16'hFFFE, 16'h0001, 16'd4, 0, 1'b0);
        run_cmd(16'h0005, 16'h0001, 16'd0, 0, 1'b0);

        // cfg_val held through a command: the second one waits for IDLE.
        clear_mon();
        tick();
        cfg_addr = 16'h0000; cfg_stride = 16'h0001; cfg_count = 16'd6; cfg_val = 1'b1; str_rdy = 1'b1;
        tick();
        cfg_addr = 16'h0100; cfg_stride = 16'h0003; cfg_count = 16'd3;
        check("gate_cfg_rdy_low", 32'(cfg_rdy), 0);
        check("gate_busy_high", 32'(busy), 1);
        wait_out(6, 100, "gate_first_outputs");
        check("gate_single_accept", n_acc, 1);
        check("gate_first_reads", q_rd.size(), 6);
        tick();
        cfg_val = 1'b0;
        check("gate_second_accept", n_acc, 2);
        wait_out(9, 100, "gate_second_outputs");
        if (q_out.size() >= 9) begin
            check("gate_w6", 32'(q_out[6]), 32'(mem[16'h0100]));
            check("gate_w7", 32'(q_out[7]), 32'(mem[16'h0103]));
            check("gate_w8", 32'(q_out[8]), 32'(mem[16'h0106]));
            check("gate_last5", 32'(q_last[5]), 1);
            check("gate_last8", 32'(q_last[8]), 1);
        end
        repeat (2) tick();

        // Reset in the middle of issuing a 16-word command.
        clear_mon();
        cfg_addr = 16'h0020; cfg_stride = 16'h0001; cfg_count = 16'd16; cfg_val = 1'b1; str_rdy = 1'b1;
        tick();
        cfg_val = 1'b0;
        repeat (6) tick();
        check("midrst_busy_before", 32'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_cfg_rdy", 32'(cfg_rdy), 1);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_mem_rd_val", 32'(mem_rd_val), 0);
        check("midrst_mem_rd_addr", 32'(mem_rd_addr), 0);
        check("midrst_str_val", 32'(str_val), 0);
        check("midrst_str_last", 32'(str_last), 0);
        check("midrst_str_data", 32'(str_data), 0);
        clear_mon();
        repeat (6) tick();
        check("midrst_late_ignored", q_out.size(), 0);
        check("midrst_no_reads", q_rd.size(), 0);
        run_cmd(16'h0040, 16'h0001, 16'd3, 0, 1'b0);

        // Random contents, addresses, strides and downstream readiness.
        for (int i = 0; i < 65536; i++) mem[i] = DW'($urandom);
        for (int r = 0; r < 6; r++)
            run_cmd(AW'($urandom), AW'($urandom), CW'($urandom_range(1, 20)), 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/image_fetch.md
# image_fetch

Read-side sequencer for `image_mem`. It accepts a strided read command (base address, word count, stride) through a valid/ready handshake and issues one `image_mem` read per cycle. Returned words are buffered in a credit-controlled FIFO and presented as a valid/ready stream with a last flag. It sits between the layer controller and the convolution datapath, and is the consumer counterpart of the stream-fed `image_mem` write port.

## Interface
- `GROUP_NB`, 1: image words per memory read.
- `IMG_WIDTH`, 16: bits per image word.
- `MEM_AWIDTH`, 16: memory address width.
- `CNT_WIDTH`, 16: command word-count width.
- `MEM_LATENCY`, 2: fixed cycles from `mem_rd_val` high to matching `mem_rd_data_val` high.
- `FIFO_DEPTH`, 4: return-buffer entries (power of two, ≥ MEM_LATENCY+2).
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_val` in 1: command valid.
- `cfg_rdy` out 1: command accepted when `cfg_val & cfg_rdy`.
- `cfg_addr` in MEM_AWIDTH: first read address.
- `cfg_stride` in MEM_AWIDTH: address increment per read.
- `cfg_count` in CNT_WIDTH: number of reads.
- `mem_rd_val` out 1: memory read strobe.
- `mem_rd_addr` out MEM_AWIDTH: memory read address.
- `mem_rd_data` in GROUP_NB*IMG_WIDTH: memory read data.
- `mem_rd_data_val` in 1: memory read data valid.
- `str_val` out 1: output word valid.
- `str_rdy` in 1: downstream ready.
- `str_data` out GROUP_NB*IMG_WIDTH: output word.
- `str_last` out 1: final word of the command; qualified by `str_val`.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - `cfg_rdy`=1.
  - On handshake, latch addr, stride and count. Count 0 stays in IDLE and produces no output. Otherwise go to ISSUE.
- ISSUE:
  - Issue a read when credit < FIFO_DEPTH: `mem_rd_val`=1, `mem_rd_addr`=current address.
  - After each issue, address += stride, modulo 2^MEM_AWIDTH (wrap silently).
  - Issue count decrements; the last issue moves to DRAIN.
- DRAIN: wait until the final word has completed a `str_val & str_rdy` handshake, then go to IDLE.
- Credit counter:
  - Increments on each issue and decrements on each output handshake; both in one cycle leave it unchanged.
  - It covers in-flight reads plus FIFO occupancy, so the FIFO can never overflow.
- FIFO:
  - Writes on `mem_rd_data_val`; `str_val` = FIFO not empty; `str_data` = FIFO head.
  - `mem_rd_data_val` is ignored in IDLE.
- Output counter: counts handshakes; `str_last`=1 when the head is the count-th word.
- `cfg_rdy`=0 outside IDLE. A new command is accepted only after DRAIN completes.

## Timing
- Reset values:
  - State IDLE; FIFO and counters cleared.
  - `cfg_rdy`=1, `busy`=0.
  - `mem_rd_val`=0, `mem_rd_addr`=0.
  - `str_val`=0, `str_last`=0, `str_data`=0.
- `rst` mid-command:
  - Abort the command and return to IDLE next cycle.
  - Pending memory returns are dropped.
- `mem_rd_val`/`mem_rd_addr` are registered. With the command handshake at edge 0, the first read is high in cycle 1.
- First word arrives at cycle 1+MEM_LATENCY and is written into the FIFO at that edge. First `str_val` is high in cycle 2+MEM_LATENCY.
- Throughput: with `str_rdy` held high, one read and one output word per cycle sustained.
- Backpressure:
  - With `str_rdy`=0, issue stops once credit = FIFO_DEPTH.
  - `str_val`, `str_data` and `str_last` stay stable until the handshake.
- `busy` falls in the cycle after the last handshake; `cfg_rdy` rises in that same cycle.

## Test plan
- **Linear read.** Memory holds word i = i. Send addr 0, stride 1, count 11 with `str_rdy`=1.
  - Required: reads in cycles 1..11.
  - Required: `str_data` 0..10 on consecutive cycles, `str_last` only on 10.
  - Required: `busy` low and `cfg_rdy` high one cycle after that handshake.
- **Even/odd stride.**
  - addr 0, stride 2, count 6 → 0,2,4,6,8,10.
  - addr 1, stride 2, count 6 → 1,3,5,7,9,11.
- **Backpressure.** count 10 with `str_rdy`=0 for 20 cycles, then 1.
  - Required: exactly FIFO_DEPTH reads issued while stalled.
  - Required: no word lost or duplicated; output order 0..9.
  - Required: `str_data` stable while stalled.
- **Address wrap.** addr 0xFFFE, stride 1, count 4 → read addresses FFFE, FFFF, 0000, 0001.
- **Count zero and command gating.**
  - count 0 → no `mem_rd_val`, no `str_val`, `cfg_rdy` stays high.
  - A `cfg_val` held high during ISSUE is not accepted until IDLE.
- **Reset mid-command.** Assert `rst` during ISSUE of count 16.
  - Required: the next cycle shows IDLE reset values.
  - Required: late `mem_rd_data_val` is ignored.
  - Required: a following count-3 command returns exactly 3 correct words.
